// File: rtl/prog_fetch_ctrl.sv
// Program-image fetcher: reads a length header from SRAM, then streams that many words out through a small FIFO.
// One SRAM read per READ_WAIT cycles; reads stall (bus idles) whenever buffered + in-flight words would exceed the FIFO.
module prog_fetch_ctrl #(
    parameter int          ADDR_W     = 20,
    parameter int          DATA_W     = 16,
    parameter int unsigned BASE_ADDR  = 0,
    parameter int          READ_WAIT  = 2,
    parameter int          FIFO_DEPTH = 8,
    parameter int          MAX_WORDS  = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] data_input,
    output logic [ADDR_W-1:0] input_addr,
    output logic              mem_cen,
    output logic              mem_oen,
    output logic              mem_wen,
    output logic              mem_lbn,
    output logic              mem_ubn,
    output logic [DATA_W-1:0] word_data,
    output logic              word_valid,
    input  logic              word_ready,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int REM_W  = $clog2(MAX_WORDS + 1);
    localparam int WCNT_W = (READ_WAIT > 1) ? $clog2(READ_WAIT) : 1;

    localparam logic [ADDR_W-1:0] BASE_A    = ADDR_W'(BASE_ADDR);
    localparam logic [WCNT_W-1:0] WAIT_INIT = WCNT_W'(READ_WAIT - 1);
    localparam logic [CNT_W:0]    DEPTH_C   = (CNT_W + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_FETCH,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t              state_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [ADDR_W-1:0]   input_addr_q;
    logic [REM_W-1:0]    rem_q;
    logic [WCNT_W-1:0]   wcnt_q;
    logic                cen_q;
    logic                busy_q;
    logic                done_q;
    logic                err_q;
    logic [DATA_W-1:0]   mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q;
    logic [PTR_W-1:0]    rd_ptr_q;
    logic [CNT_W-1:0]    count_q;

    logic                sample;
    logic                push;
    logic                pop;
    logic                bus_free;
    logic                issue;
    logic [REM_W-1:0]    rem_left;
    logic [CNT_W:0]      occupancy;
    logic [CNT_W-1:0]    count_d;
    logic [31:0]         hdr_len;

    always_comb begin
        sample    = !cen_q && (wcnt_q == '0);
        push      = sample && (state_q == S_FETCH);
        pop       = (count_q != '0) && word_ready;
        bus_free  = cen_q || sample;
        rem_left  = sample ? rem_q - 1'b1 : rem_q;
        // A read in flight already owns a FIFO slot; counting it keeps pushes from ever hitting a full FIFO.
        occupancy = {1'b0, count_q} + {{CNT_W{1'b0}}, !cen_q};
        issue     = (state_q == S_FETCH) && bus_free && (rem_left != '0) && (occupancy < DEPTH_C);
        count_d   = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!push && pop) begin
            count_d = count_q - 1'b1;
        end
        hdr_len   = 32'(data_input);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            input_addr_q <= '0;
            rem_q        <= '0;
            wcnt_q       <= '0;
            cen_q        <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            count_q <= count_d;
            if (push) begin
                mem_q[wr_ptr_q] <= data_input;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (!cen_q && (wcnt_q != '0)) begin
                wcnt_q <= wcnt_q - 1'b1;
            end

            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_q <= S_HDR;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        err_q   <= 1'b0;
                    end
                end
                S_HDR: begin
                    if (cen_q) begin
                        input_addr_q <= BASE_A;
                        cen_q        <= 1'b0;
                        wcnt_q       <= WAIT_INIT;
                    end else if (sample) begin
                        cen_q <= 1'b1;
                        if (hdr_len == 32'd0) begin
                            state_q <= S_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else if (hdr_len > 32'(MAX_WORDS)) begin
                            state_q <= S_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            err_q   <= 1'b1;
                        end else begin
                            rem_q   <= hdr_len[REM_W-1:0];
                            addr_q  <= BASE_A + 1'b1;
                            state_q <= S_FETCH;
                        end
                    end
                end
                S_FETCH: begin
                    if (issue) begin
                        input_addr_q <= addr_q;
                        addr_q       <= addr_q + 1'b1;
                        cen_q        <= 1'b0;
                        wcnt_q       <= WAIT_INIT;
                    end else if (sample) begin
                        cen_q <= 1'b1;
                    end
                    if (sample) begin
                        rem_q <= rem_left;
                        if (rem_left == '0) begin
                            state_q <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (count_d == '0) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign input_addr = input_addr_q;
    assign mem_cen    = cen_q;
    assign mem_oen    = cen_q;
    assign mem_wen    = 1'b1;
    assign mem_lbn    = 1'b0;
    assign mem_ubn    = 1'b0;
    assign word_data  = mem_q[rd_ptr_q];
    assign word_valid = (count_q != '0);
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule
